conv_channel_sequencer: RTL



---
 rtl/conv_channel_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/conv_channel_sequencer.sv
// Layer sequencer for depthwise_conv3x3_engine: per output channel it walks the input
// channels, loads each 3x3 kernel from a synchronous ROM, runs the engine and accumulates.
module conv_channel_sequencer #(
    parameter int NUM_OUT_CH = 32,
    parameter int NUM_IN_CH  = 3,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 32,
    parameter int ADDR_W     = 10,
    localparam int CH_W      = (NUM_OUT_CH > 1) ? $clog2(NUM_OUT_CH) : 1
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic [NUM_IN_CH*9*DATA_W-1:0]     win_in,
    output logic                              busy,
    output logic                              done,
    output logic [ADDR_W-1:0]                 wt_addr,
    input  logic [DATA_W-1:0]                 wt_rdata,
    output logic [DATA_W-1:0]                 conv_window [0:8],
    output logic [DATA_W-1:0]                 conv_kernel [0:8],
    output logic                              conv_clear,
    output logic                              conv_start,
    input  logic signed [ACC_W-1:0]           conv_result,
    input  logic                              conv_valid,
    output logic [CH_W-1:0]                   out_ch,
    output logic signed [ACC_W-1:0]           out_data,
    output logic                              out_valid
);
    localparam int TAPS  = 9;
    localparam int NWIN  = NUM_IN_CH * TAPS;
    localparam int IC_W  = (NUM_IN_CH > 1) ? $clog2(NUM_IN_CH) : 1;
    localparam int WIX_W = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam logic [IC_W-1:0] LAST_IC = IC_W'(NUM_IN_CH - 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_OUT_CH - 1);
    localparam logic [3:0]      LAST_J  = 4'd9;

    typedef enum logic [2:0] {
        IDLE, FETCH, CLEAR, START, WAIT, ACC, EMIT, DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [IC_W-1:0]         ic_q, ic_d;
    logic [3:0]              j_q, j_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] res_q, res_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]         out_ch_q, out_ch_d;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    win_ld;
    logic                    kern_we;
    logic [DATA_W-1:0]       win_q  [0:NWIN-1];
    logic [DATA_W-1:0]       kern_q [0:TAPS-1];
    logic [ADDR_W-1:0]       fetch_addr;
    logic [WIX_W-1:0]        win_base;

    // Two's-complement accumulation that wraps silently on overflow.
    function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                         input logic signed [ACC_W-1:0] b);
        return a + b;
    endfunction

    assign acc_sum    = wrap_add(acc_q, res_q);
    assign fetch_addr = ADDR_W'(ch_q) * ADDR_W'(NWIN) + ADDR_W'(ic_q) * ADDR_W'(TAPS)
                      + ADDR_W'(j_q);
    assign wt_addr    = (state_q == FETCH && j_q < LAST_J) ? fetch_addr : '0;
    assign busy       = (state_q != IDLE);
    assign out_ch     = out_ch_q;
    assign out_data   = out_data_q;
    assign conv_kernel = kern_q;
    assign win_base   = WIX_W'(ic_q) * WIX_W'(TAPS);

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            conv_window[k] = win_q[win_base + WIX_W'(k)];
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        ic_d       = ic_q;
        j_d        = j_q;
        acc_d      = acc_q;
        res_d      = res_q;
        out_ch_d   = out_ch_q;
        out_data_d = out_data_q;
        win_ld     = 1'b0;
        kern_we    = 1'b0;
        conv_clear = 1'b0;
        conv_start = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    win_ld  = 1'b1;
                    ch_d    = '0;
                    ic_d    = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    state_d = FETCH;
                end
            end
            // ROM data lags the address by one cycle, so tap j-1 lands on cycle j.
            FETCH: begin
                kern_we = (j_q != 4'd0);
                if (j_q == LAST_J) begin
                    j_d     = '0;
                    state_d = CLEAR;
                end else begin
                    j_d = j_q + 4'd1;
                end
            end
            CLEAR: begin
                conv_clear = 1'b1;
                state_d    = START;
            end
            START: begin
                conv_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (conv_valid) begin
                    res_d   = conv_result;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d = acc_sum;
                if (ic_q == LAST_IC) begin
                    out_ch_d   = ch_q;
                    out_data_d = acc_sum;
                    state_d    = EMIT;
                end else begin
                    ic_d    = ic_q + IC_W'(1);
                    state_d = FETCH;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (ch_q == LAST_CH) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    ic_d    = '0;
                    acc_d   = '0;
                    state_d = FETCH;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            ic_q       <= '0;
            j_q        <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            out_ch_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            ic_q       <= ic_d;
            j_q        <= j_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            out_ch_q   <= out_ch_d;
            out_data_q <= out_data_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NWIN; i++) win_q[i] <= '0;
            for (int k = 0; k < TAPS; k++) kern_q[k] <= '0;
        end else begin
            if (win_ld) begin
                for (int i = 0; i < NWIN; i++) win_q[i] <= win_in[i*DATA_W +: DATA_W];
            end
            if (kern_we) begin
                kern_q[j_q - 4'd1] <= wt_rdata;
            end
        end
    end

endmodule
